// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/write-back
// sequencing, plus a retired-instruction counter and a sticky illegal-opcode flag.
module mips_multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMRD     = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWR     = 4'd5,
    S_REXEC     = 4'd6,
    S_RWB       = 4'd7,
    S_BRANCH    = 4'd8,
    S_IMMEX_ADD = 4'd9,
    S_IMMEX_SLT = 4'd10,
    S_IMMWB     = 4'd11,
    S_JUMP      = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t           state;
  state_t           state_d;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_c;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  // Moore control word for a given state; unlisted fields stay 0
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b011;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = 3'b011;
      end
      S_MEMADR, S_IMMEX_ADD: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b011;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_REXEC: c.alu_src_a = 1'b1;
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 3'b001;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_IMMEX_SLT: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b010;
      end
      S_IMMWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic; opcode only matters in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_REXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_IMMEX_ADD;
          OP_SLTI:      state_d = S_IMMEX_SLT;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:                  state_d = S_MEMWB;
      S_REXEC:                  state_d = S_RWB;
      S_IMMEX_ADD, S_IMMEX_SLT: state_d = S_IMMWB;
      default:                  state_d = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so it always equals decode(state)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      ctrl_q    <= decode(S_FETCH);
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state  <= state_d;
      ctrl_q <= decode(state_d);
      if (state == S_DECODE) begin
        if (state_d == S_FETCH) illegal_q <= 1'b1;
        else                    count_q   <= count_q + CNT_W'(1);
      end
    end
  end

  // Reset must suppress every datapath write immediately, not just after the next edge
  always_comb begin
    ctrl_c = rst_n ? ctrl_q : '0;
  end

  assign PCWrite     = ctrl_c.pc_write;
  assign PCWriteCond = ctrl_c.pc_write_cond;
  assign IorD        = ctrl_c.iord;
  assign MemRead     = ctrl_c.mem_read;
  assign MemWrite    = ctrl_c.mem_write;
  assign IRWrite     = ctrl_c.ir_write;
  assign MemtoReg    = ctrl_c.mem_to_reg;
  assign RegDst      = ctrl_c.reg_dst;
  assign RegWrite    = ctrl_c.reg_write;
  assign ALUSrcA     = ctrl_c.alu_src_a;
  assign ALUSrcB     = ctrl_c.alu_src_b;
  assign ALUOp       = ctrl_c.alu_op;
  assign PCSource    = ctrl_c.pc_source;
  assign state_o     = state;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control (4-bit counter instance to reach wrap).
module tb_mips_multicycle_control;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state_o;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_cnt;

  mips_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state_o(state_o), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  logic [16:0] obs_ctrl;
  assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  function automatic logic [16:0] exp_ctrl(input logic [3:0] st);
    case (st)
      4'd0:    return 17'b1_0_0_1_0_1_0_0_0_0_01_011_00;
      4'd1:    return 17'b0_0_0_0_0_0_0_0_0_0_11_011_00;
      4'd2:    return 17'b0_0_0_0_0_0_0_0_0_1_10_011_00;
      4'd3:    return 17'b0_0_1_1_0_0_0_0_0_0_00_000_00;
      4'd4:    return 17'b0_0_0_0_0_0_1_0_1_0_00_000_00;
      4'd5:    return 17'b0_0_1_0_1_0_0_0_0_0_00_000_00;
      4'd6:    return 17'b0_0_0_0_0_0_0_0_0_1_00_000_00;
      4'd7:    return 17'b0_0_0_0_0_0_0_1_1_0_00_000_00;
      4'd8:    return 17'b0_1_0_0_0_0_0_0_0_1_00_001_01;
      4'd9:    return 17'b0_0_0_0_0_0_0_0_0_1_10_011_00;
      4'd10:   return 17'b0_0_0_0_0_0_0_0_0_1_10_010_00;
      4'd11:   return 17'b0_0_0_0_0_0_0_0_1_0_00_000_00;
      4'd12:   return 17'b1_0_0_0_0_0_0_0_0_0_00_000_10;
      default: return 17'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Walks one instruction; seq holds expected states as nibbles (first state in bits [3:0]).
  // Opcode is valid only where the FSM samples it, garbage elsewhere.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [23:0] seq, input int len);
    logic [3:0] st;
    for (int i = 0; i < len; i++) begin
      st = seq[4*i +: 4];
      opcode = (st == 4'd1 || st == 4'd2) ? op : 6'b111111;
      @(negedge clk);
      check($sformatf("%s state[%0d]", name, i), 32'(state_o), 32'(st));
      check($sformatf("%s ctrl[%0d]", name, i), 32'(obs_ctrl), 32'(exp_ctrl(st)));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic post_check(input string name, input logic exp_ill);
    check({name, " instr_count"}, 32'(instr_count), 32'(exp_cnt));
    check({name, " illegal_op"}, 32'(illegal_op), 32'(exp_ill));
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b100011;
    exp_cnt = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctrl", 32'(obs_ctrl), 32'd0);
    check("reset state", 32'(state_o), 32'd0);
    post_check("reset", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr("lw", 6'b100011, 24'h043210, 5);
    exp_cnt = 4'd1;  post_check("lw", 1'b0);
    run_instr("r", 6'b000000, 24'h007610, 4);
    exp_cnt = 4'd2;  post_check("r", 1'b0);
    run_instr("slti", 6'b001010, 24'h00BA10, 4);
    exp_cnt = 4'd3;  post_check("slti", 1'b0);
    run_instr("beq", 6'b000100, 24'h000810, 3);
    exp_cnt = 4'd4;  post_check("beq", 1'b0);
    run_instr("j", 6'b000010, 24'h000C10, 3);
    exp_cnt = 4'd5;  post_check("j", 1'b0);
    run_instr("sw", 6'b101011, 24'h005210, 4);
    exp_cnt = 4'd6;  post_check("sw", 1'b0);
    run_instr("illegal", 6'b111111, 24'h000010, 2);
    post_check("illegal", 1'b1);
    run_instr("addi", 6'b001000, 24'h00B910, 4);
    exp_cnt = 4'd7;  post_check("addi", 1'b1);

    // Abandon an LW in MEMRD: no write-back, everything cleared
    run_instr("lw_abort", 6'b100011, 24'h000210, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort memrd state", 32'(state_o), 32'd3);
    check("abort memrd ctrl", 32'(obs_ctrl), 32'd0);
    @(posedge clk);
    #1;
    exp_cnt = 4'd0;
    check("abort state", 32'(state_o), 32'd0);
    post_check("abort", 1'b0);
    @(negedge clk);
    check("abort no regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sixteen legal instructions wrap the 4-bit counter back to 0
    for (int k = 0; k < 16; k++) begin
      case (k % 7)
        0: run_instr("wrap_lw",   6'b100011, 24'h043210, 5);
        1: run_instr("wrap_sw",   6'b101011, 24'h005210, 4);
        2: run_instr("wrap_r",    6'b000000, 24'h007610, 4);
        3: run_instr("wrap_beq",  6'b000100, 24'h000810, 3);
        4: run_instr("wrap_addi", 6'b001000, 24'h00B910, 4);
        5: run_instr("wrap_slti", 6'b001010, 24'h00BA10, 4);
        default: run_instr("wrap_j", 6'b000010, 24'h000C10, 3);
      endcase
      exp_cnt = exp_cnt + 4'd1;
      post_check($sformatf("wrap[%0d]", k), 1'b0);
    end
    check("wrap final count", 32'(instr_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
